// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared control-unit definitions for the T-state / M-cycle sequencer:
// one-hot step constants, fetch M-cycle code, state encoding and NOP opcode.
package cpu_cycle_sequencer_pkg;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0100;
    localparam logic [3:0] T4 = 4'b1000;

    localparam logic [7:0] MC_FETCH   = 8'h01;
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/one_hot_ring.sv
// One-hot rotating register with synchronous reset, load-first, hold and shift.
// Priority: reset, load_first, hold, shift; otherwise the value is kept.
module one_hot_ring #(
    parameter int                 P_WIDTH = 4,
    parameter logic [P_WIDTH-1:0] P_FIRST = {{(P_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               load_first,
    input  logic               hold,
    output logic [P_WIDTH-1:0] ring
);

    logic [P_WIDTH-1:0] ring_r;

    function automatic logic [P_WIDTH-1:0] rotate_left(input logic [P_WIDTH-1:0] v);
        return {v[P_WIDTH-2:0], v[P_WIDTH-1]};
    endfunction

    // Ring register update
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_r <= P_FIRST;
        end else if (load_first) begin
            ring_r <= P_FIRST;
        end else if (hold) begin
            ring_r <= ring_r;
        end else if (shift) begin
            ring_r <= rotate_left(ring_r);
        end else begin
            ring_r <= ring_r;
        end
    end

    assign ring = ring_r;

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// T-state / M-cycle timing generator for the microcode control unit, with
// opcode latch, bus wait stretching, HALT/wake and sticky M-cycle overrun fault.
module cpu_cycle_sequencer
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter int         P_MAX_MCYCLES  = 8,
    parameter logic [7:0] P_RESET_OPCODE = NOP_OPCODE
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_IR_Fetch,
    input  logic                     i_Wait,
    input  logic                     i_Halt_Req,
    input  logic                     i_Wake,
    input  logic [7:0]               i_Data_Bus,
    output logic [3:0]               o_Cycle_Step,
    output logic [P_MAX_MCYCLES-1:0] o_Cycle_Count,
    output logic [7:0]               o_Opcode,
    output logic                     o_Halted,
    output logic                     o_Fault
);

    localparam logic [P_MAX_MCYCLES-1:0] COUNT_FIRST = P_MAX_MCYCLES'(MC_FETCH);

    seq_state_e                state_r;
    seq_state_e                state_nxt_s;
    logic [7:0]                opcode_r;
    logic                      halted_r;
    logic                      fault_r;
    logic [3:0]                step_s;
    logic [P_MAX_MCYCLES-1:0]  count_s;

    logic step_shift_s, step_load_s, step_hold_s;
    logic cnt_shift_s, cnt_load_s, cnt_hold_s;
    logic fault_set_s, opc_latch_s;
    logic step_t2_s, step_t3_s, step_t4_s, cnt_fetch_s, cnt_last_s;

    assign step_t2_s   = |(step_s & T2);
    assign step_t3_s   = |(step_s & T3);
    assign step_t4_s   = |(step_s & T4);
    assign cnt_fetch_s = |(count_s & COUNT_FIRST);
    assign cnt_last_s  = count_s[P_MAX_MCYCLES-1];

    one_hot_ring #(
        .P_WIDTH (4),
        .P_FIRST (T1)
    ) u_step_ring (
        .clk        (i_Clk),
        .reset      (i_Reset),
        .shift      (step_shift_s),
        .load_first (step_load_s),
        .hold       (step_hold_s),
        .ring       (step_s)
    );

    one_hot_ring #(
        .P_WIDTH (P_MAX_MCYCLES),
        .P_FIRST (COUNT_FIRST)
    ) u_count_ring (
        .clk        (i_Clk),
        .reset      (i_Reset),
        .shift      (cnt_shift_s),
        .load_first (cnt_load_s),
        .hold       (cnt_hold_s),
        .ring       (count_s)
    );

    // Next-state and ring control decode
    always_comb begin
        state_nxt_s  = state_r;
        step_shift_s = 1'b0;
        step_load_s  = 1'b0;
        step_hold_s  = 1'b0;
        cnt_shift_s  = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_hold_s   = 1'b0;
        fault_set_s  = 1'b0;
        opc_latch_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (step_t2_s && i_Wait) begin
                    state_nxt_s = ST_WAIT;
                    step_hold_s = 1'b1;
                    cnt_hold_s  = 1'b1;
                end else begin
                    step_shift_s = 1'b1;
                    opc_latch_s  = step_t3_s && cnt_fetch_s;
                    // Fetch boundary: restart, halt, overrun or next M-cycle
                    if (step_t4_s) begin
                        if (i_IR_Fetch) begin
                            cnt_load_s = 1'b1;
                            if (i_Halt_Req) begin
                                state_nxt_s = ST_HALT;
                                step_load_s = 1'b1;
                            end else begin
                                state_nxt_s = ST_RUN;
                            end
                        end else if (cnt_last_s) begin
                            cnt_load_s  = 1'b1;
                            fault_set_s = 1'b1;
                        end else begin
                            cnt_shift_s = 1'b1;
                        end
                    end else begin
                        cnt_hold_s = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (i_Wait) begin
                    step_hold_s = 1'b1;
                    cnt_hold_s  = 1'b1;
                end else begin
                    state_nxt_s  = ST_RUN;
                    step_shift_s = 1'b1;
                    cnt_hold_s   = 1'b1;
                end
            end
            ST_HALT: begin
                if (i_Wake) begin
                    state_nxt_s = ST_RUN;
                    step_load_s = 1'b1;
                    cnt_load_s  = 1'b1;
                end else begin
                    step_hold_s = 1'b1;
                    cnt_hold_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                step_load_s = 1'b1;
                cnt_load_s  = 1'b1;
            end
        endcase
    end

    // State register, opcode latch, halt flag and sticky fault
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r  <= ST_RUN;
            opcode_r <= P_RESET_OPCODE;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            halted_r <= (state_nxt_s == ST_HALT);
            fault_r  <= fault_r | fault_set_s;
            if (opc_latch_s) begin
                opcode_r <= i_Data_Bus;
            end else begin
                opcode_r <= opcode_r;
            end
        end
    end

    assign o_Cycle_Step  = step_s;
    assign o_Cycle_Count = count_s;
    assign o_Opcode      = opcode_r;
    assign o_Halted      = halted_r;
    assign o_Fault       = fault_r;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Scoreboard bench for cpu_cycle_sequencer: a behavioural model predicts every
// output each clock; predictions are queued on drive and popped after the edge.
module tb_cpu_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset, ir_fetch, wait_in, halt_req, wake;
    logic [7:0] data_bus;
    logic [3:0] cycle_step;
    logic [7:0] cycle_count;
    logic [7:0] opcode;
    logic       halted, fault;

    typedef struct packed {
        logic [3:0] step;
        logic [7:0] count;
        logic [7:0] opc;
        logic       halted;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    // Model state: T index 0..3, M index 0..7, 0=run 1=wait 2=halt
    int         m_t, m_c, m_st;
    logic [7:0] m_opc;
    logic       m_fault;
    int         fetch_at = 3;
    bit         hold_data = 1'b0;

    cpu_cycle_sequencer dut (
        .i_Clk         (clk),
        .i_Reset       (reset),
        .i_IR_Fetch    (ir_fetch),
        .i_Wait        (wait_in),
        .i_Halt_Req    (halt_req),
        .i_Wake        (wake),
        .i_Data_Bus    (data_bus),
        .o_Cycle_Step  (cycle_step),
        .o_Cycle_Count (cycle_count),
        .o_Opcode      (opcode),
        .o_Halted      (halted),
        .o_Fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_t = 0; m_c = 0; m_st = 0; m_opc = 8'h00; m_fault = 1'b0;
        end else if (m_st == 0) begin
            if (m_t == 1 && wait_in) begin
                m_st = 1;
            end else begin
                if (m_t == 2 && m_c == 0) m_opc = data_bus;
                if (m_t == 3) begin
                    if (ir_fetch) begin
                        m_c = 0;
                        if (halt_req) m_st = 2;
                    end else if (m_c == 7) begin
                        m_c = 0;
                        m_fault = 1'b1;
                    end else begin
                        m_c = m_c + 1;
                    end
                end
                m_t = (m_t + 1) % 4;
            end
        end else if (m_st == 1) begin
            if (!wait_in) begin
                m_st = 0;
                m_t = 2;
            end
        end else begin
            if (wake) begin
                m_st = 0; m_t = 0; m_c = 0;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        ir_fetch = (fetch_at >= 0) && (m_c >= fetch_at);
        if (!hold_data) data_bus = 8'($urandom);
        model_update();
        e.step   = 4'(1 << m_t);
        e.count  = 8'(1 << m_c);
        e.opc    = m_opc;
        e.halted = (m_st == 2);
        e.fault  = m_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("step",   32'(cycle_step),  32'(e.step));
        check_val("count",  32'(cycle_count), 32'(e.count));
        check_val("opcode", 32'(opcode),      32'(e.opc));
        check_val("halted", 32'(halted),      32'(e.halted));
        check_val("fault",  32'(fault),       32'(e.fault));
    endtask

    task automatic run_until(input int t, input int c);
        int n = 0;
        while (!(m_st == 0 && m_t == t && (c < 0 || m_c == c)) && n < 200) begin
            tick();
            n++;
        end
        check_val("run_until_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_step"},   32'(cycle_step),  32'h1);
        check_val({tag, "_count"},  32'(cycle_count), 32'h1);
        check_val({tag, "_opcode"}, 32'(opcode),      32'h0);
        check_val({tag, "_halted"}, 32'(halted),      32'h0);
        check_val({tag, "_fault"},  32'(fault),       32'h0);
    endtask

    initial begin
        reset = 1'b1; ir_fetch = 1'b0; wait_in = 1'b0; halt_req = 1'b0;
        wake = 1'b0; data_bus = 8'h00;
        m_t = 0; m_c = 0; m_st = 0; m_opc = 8'h00; m_fault = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("reset");

        // Free run, fetch requested from count[3]
        fetch_at = 3;
        repeat (32) tick();

        // Wait stretch on the fetch M-cycle with a late opcode
        run_until(1, 0);
        wait_in = 1'b1;
        repeat (3) tick();
        check_val("wait_hold_step", 32'(cycle_step), 32'h2);
        wait_in = 1'b0;
        data_bus = 8'hA5;
        hold_data = 1'b1;
        tick();
        tick();
        hold_data = 1'b0;
        check_val("late_opcode", 32'(opcode), 32'hA5);
        repeat (6) tick();

        // HALT entry, frozen for 10 clocks, wake
        run_until(3, 3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_val("halt_entry", 32'(halted), 32'h1);
        repeat (10) tick();
        check_val("halt_frozen_step", 32'(cycle_step), 32'h1);
        wake = 1'b1;
        tick();
        wake = 1'b0;
        check_val("wake_exit", 32'(halted), 32'h0);
        repeat (8) tick();

        // Wake coincident with HALT entry: halt first, wake next clock
        run_until(3, 3);
        halt_req = 1'b1;
        wake = 1'b1;
        tick();
        halt_req = 1'b0;
        check_val("halt_with_wake", 32'(halted), 32'h1);
        tick();
        wake = 1'b0;
        check_val("wake_after", 32'(halted), 32'h0);
        repeat (4) tick();

        // Overrun: no fetch for more than 8 M-cycles
        fetch_at = -1;
        repeat (40) tick();
        check_val("fault_set", 32'(fault), 32'h1);
        fetch_at = 3;
        repeat (12) tick();
        check_val("fault_sticky", 32'(fault), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("fault_clear");

        // Reset mid-WAIT
        run_until(1, 0);
        wait_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_in = 1'b0;
        check_reset_values("rst_wait");
        repeat (6) tick();

        // Reset in HALT
        run_until(3, 3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("rst_halt");

        // Halt request without fetch, wait outside step[1]: both ignored
        for (int i = 0; i < 48; i++) begin
            halt_req = (m_c < fetch_at);
            wait_in  = (m_st == 0 && m_t == 1) ? 1'b0 : 1'($urandom);
            tick();
        end
        halt_req = 1'b0;
        wait_in = 1'b0;
        check_val("halt_req_ignored", 32'(halted), 32'h0);
        check_val("no_fault", 32'(fault), 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
